// File: rtl/aibcr3_dll_thm2gry64_if.sv
// Bus bundle for the DLL thermometer-to-Gray readback encoder.
// thm is taken on a rising edge where thm_vld=1 (no backpressure); grey_vld pulses one cycle per committed code.
interface aibcr3_dll_thm2gry64_if;
    logic [63:0] thm;
    logic        thm_vld;
    logic        err_clr;
    logic [6:0]  grey;
    logic        grey_vld;
    logic        err;
    logic        locked;
    logic [0:0]  fsm_state;

    modport master (
        output thm, thm_vld, err_clr,
        input  grey, grey_vld, err, locked, fsm_state
    );

    modport slave (
        input  thm, thm_vld, err_clr,
        output grey, grey_vld, err, locked, fsm_state
    );
endinterface

// File: rtl/aibcr3_dll_thm2gry64.sv
// Registered, filtered 64-bit thermometer to 7-bit Gray encoder for DLL readback.
// Define AIBCR3_THM2GRY_BUBBLE_FIX_EN to majority-filter single-bit bubbles before counting.
module aibcr3_dll_thm2gry64 #(
    parameter int FILT_CNT = 3
) (
    input  logic                        CLKIN,
    input  logic                        RSTb,
    aibcr3_dll_thm2gry64_if.slave       bus
);
    localparam logic [0:0] ACQ   = 1'b0;
    localparam logic [0:0] TRACK = 1'b1;
    localparam logic [2:0] FILT  = 3'(FILT_CNT);

    logic [63:0] thm_q;
    logic        vld_q;
    logic [63:0] thm_f;
    logic [6:0]  n_raw;
    logic [64:0] mask;
    logic        mono;
    logic [6:0]  n_q;
    logic        nvld_q;
    logic        nerr_q;
    logic [6:0]  cand;
    logic [6:0]  cand_nx;
    logic [2:0]  cnt;
    logic [2:0]  cnt_nx;
    logic [6:0]  gry_n;
    logic        commit;
    logic        set_err;
    logic [0:0]  state;
    logic [6:0]  grey;
    logic        grey_vld;
    logic        err;
    logic        locked;

    // E0: sample capture
    always_ff @(posedge CLKIN or negedge RSTb) begin
        if (!RSTb) begin
            thm_q <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= bus.thm_vld;
            if (bus.thm_vld) thm_q <= bus.thm;
        end
    end

`ifdef AIBCR3_THM2GRY_BUBBLE_FIX_EN
    // Pad below with 1 and above with 0 so the ends of the line vote like a clean code.
    logic [65:0] thm_pad;
    always_comb begin
        thm_pad = {1'b0, thm_q, 1'b1};
        thm_f   = '0;
        for (int k = 0; k < 64; k++) begin
            thm_f[k] = (thm_pad[k] & thm_pad[k+1]) | (thm_pad[k] & thm_pad[k+2]) |
                       (thm_pad[k+1] & thm_pad[k+2]);
        end
    end
`else
    assign thm_f = thm_q;
`endif

    // E1: N is the lowest zero; the word is monotonic only if it equals N ones.
    always_comb begin
        n_raw = 7'd64;
        for (int k = 63; k >= 0; k--) begin
            if (!thm_f[k]) n_raw = 7'(k);
        end
        mask = (65'd1 << n_raw) - 65'd1;
        mono = (thm_f == mask[63:0]);
    end

    always_ff @(posedge CLKIN or negedge RSTb) begin
        if (!RSTb) begin
            n_q    <= '0;
            nvld_q <= 1'b0;
            nerr_q <= 1'b0;
        end else begin
            n_q    <= n_raw;
            nvld_q <= vld_q;
            nerr_q <= vld_q & ~mono;
        end
    end

    // E2: consecutive-sample filter; in TRACK an unchanged code is committed silently.
    always_comb begin
        cnt_nx  = cnt;
        cand_nx = cand;
        set_err = 1'b0;
        commit  = 1'b0;
        gry_n   = n_q ^ (n_q >> 1);
        if (nvld_q) begin
            if (nerr_q) begin
                set_err = 1'b1;
                cnt_nx  = '0;
            end else begin
                if (n_q == cand && cnt != 3'd0) begin
                    cnt_nx = (cnt >= FILT) ? FILT : cnt + 3'd1;
                end else begin
                    cand_nx = n_q;
                    cnt_nx  = 3'd1;
                end
                if (cnt_nx == FILT) commit = (state == ACQ) || (gry_n != grey);
            end
        end
    end

    always_ff @(posedge CLKIN or negedge RSTb) begin
        if (!RSTb) begin
            cand     <= '0;
            cnt      <= '0;
            grey     <= '0;
            grey_vld <= 1'b0;
            err      <= 1'b0;
            locked   <= 1'b0;
            state    <= ACQ;
        end else begin
            cand     <= cand_nx;
            cnt      <= cnt_nx;
            grey_vld <= commit;
            err      <= set_err | (err & ~bus.err_clr);
            if (commit) begin
                grey   <= gry_n;
                locked <= 1'b1;
                state  <= TRACK;
            end
        end
    end

    assign bus.grey      = grey;
    assign bus.grey_vld  = grey_vld;
    assign bus.err       = err;
    assign bus.locked    = locked;
    assign bus.fsm_state = state;
endmodule
